serial_paralelo_azul: RTL

Receive end of the azul parallel-to-serial link. Takes the 1-bit MSB-first serial stream at clk32_f, hunts for the 0xBC idle/comma symbol to find byte alignment, and declares lock after a run of aligned commas. Once locked, it delivers each non-comma byte in parallel with a valid flag, held for one full byte period so the slower byte domain can sample it.

---
 rtl/serial_paralelo_azul_pkg.sv | 19 +
 rtl/serial_paralelo_azul.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_paralelo_azul_pkg.sv
// Shared constants for the azul serial link (both transmitter and receiver ends).
// Receiver FSM encoding, byte width and the idle/comma symbol live here so both ends agree.
package serial_paralelo_azul_pkg;

    localparam int unsigned BYTE_W = 8;

    // Idle/comma symbol sent by the transmitter whenever it has no valid byte.
    localparam logic [BYTE_W-1:0] BC_SYM_DEFAULT = 8'hBC;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    function automatic logic is_comma(input logic [BYTE_W-1:0] w,
                                      input logic [BYTE_W-1:0] sym);
        return (w == sym);
    endfunction

endpackage

// File: rtl/serial_paralelo_azul.sv
// Azul link receiver: comma-based byte alignment, lock detection and parallel byte delivery.
// Optional macro SP_BYTE_CNT_EN adds a 16-bit count of delivered (non-comma) bytes.
module serial_paralelo_azul
    import serial_paralelo_azul_pkg::*;
#(
    parameter logic [BYTE_W-1:0] BC_SYM  = BC_SYM_DEFAULT,
    parameter int unsigned       BC_LOCK = 4
) (
    input  logic              clk32_f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
`ifdef SP_BYTE_CNT_EN
    ,
    output logic [15:0]       byte_cnt
`endif
);

    localparam logic [3:0] LOCK_LAST = 4'(BC_LOCK - 1);

    if (BC_LOCK < 2 || BC_LOCK > 15) begin : g_bad_lock
        $error("BC_LOCK must be in 2..15");
    end

    logic [1:0]        state, state_next;
    logic [6:0]        sr;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [3:0]        bc_cnt, bc_cnt_next;
    logic [BYTE_W-1:0] data_next;
    logic              valid_next;
    logic [BYTE_W-1:0] word;
    logic              boundary;
    logic              comma;
    logic              load_byte;

    // Only the low seven bits of the shift history are ever needed to form the next byte.
    assign word     = {sr, data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign comma    = is_comma(word, BC_SYM);

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt + 3'd1;
        bc_cnt_next  = bc_cnt;
        data_next    = data_out;
        valid_next   = valid_out;
        load_byte    = 1'b0;

        unique case (state)
            ST_SEARCH: begin
                valid_next = 1'b0;
                if (comma) begin
                    bit_cnt_next = 3'd0;
                    bc_cnt_next  = 4'd1;
                    state_next   = ST_SYNC;
                end
            end
            ST_SYNC: begin
                valid_next = 1'b0;
                if (boundary) begin
                    if (comma) begin
                        if (bc_cnt == LOCK_LAST) begin
                            state_next = ST_ACTIVE;
                        end else begin
                            bc_cnt_next = bc_cnt + 4'd1;
                        end
                    end else begin
                        bc_cnt_next = 4'd0;
                        state_next  = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                // Outputs change only at byte boundaries, giving the byte domain 8 stable cycles.
                if (boundary) begin
                    if (comma) begin
                        valid_next = 1'b0;
                    end else begin
                        data_next  = word;
                        valid_next = 1'b1;
                        load_byte  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_SEARCH;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk32_f or negedge reset) begin
        if (!reset) begin
            state     <= ST_SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= word[6:0];
            bit_cnt   <= bit_cnt_next;
            bc_cnt    <= bc_cnt_next;
            data_out  <= data_next;
            valid_out <= valid_next;
            active    <= (state_next == ST_ACTIVE);
        end
    end

`ifdef SP_BYTE_CNT_EN
    always_ff @(posedge clk32_f or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
        end else if (load_byte) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`else
    logic unused_load_byte;
    assign unused_load_byte = load_byte;
`endif

endmodule
